// File: rtl/hilo_muldiv_engine.sv
// hilo_muldiv_engine: multi-cycle mult/div unit owning the HI/LO registers, with mthi/mtlo writes.
module hilo_muldiv_engine #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hilo_sel,
  input  logic [2:0]  op,
  input  logic        start,
  input  logic        hilo_we,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    op_q;
  logic [31:0]   a_q, b_q, hi_q, lo_q;
  logic          busy_q;
  logic          sgn, neg_a, neg_b, done, div_zero;
  logic [63:0]   ext_a, ext_b, prod;
  logic [31:0]   mag_a, mag_b, quo, rem, hi_d, lo_d;
  // One shared multiplier and one unsigned divider; signed forms fix up signs around them.
  always_comb begin
    sgn      = op_q[0];
    neg_a    = sgn & a_q[31];
    neg_b    = sgn & b_q[31];
    ext_a    = {{32{neg_a}}, a_q};
    ext_b    = {{32{neg_b}}, b_q};
    prod     = ext_a * ext_b;
    mag_a    = neg_a ? -a_q : a_q;
    mag_b    = neg_b ? -b_q : b_q;
    div_zero = (b_q == 32'd0);
    quo      = div_zero ? 32'd0 : mag_a / mag_b;
    rem      = div_zero ? 32'd0 : mag_a % mag_b;
    lo_d     = op_q[1] ? ((neg_a ^ neg_b) ? -quo : quo) : prod[31:0];
    hi_d     = op_q[1] ? (neg_a ? -rem : rem) : prod[63:32];
    done     = (state_q == RUN) && (cnt_q == CW'(1));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else if (state_q == IDLE) begin
      if (start && !op[2]) begin
        state_q <= RUN;
        busy_q  <= 1'b1;
        op_q    <= op[1:0];
        a_q     <= src_a;
        b_q     <= src_b;
        cnt_q   <= op[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
      end else if (hilo_we && !start) begin
        if (hilo_sel) hi_q <= src_a;
        else lo_q <= src_a;
      end
    end else begin
      cnt_q <= cnt_q - CW'(1);
      if (done) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        if (!(op_q[1] && div_zero)) begin
          hi_q <= hi_d;
          lo_q <= lo_d;
        end
      end
    end
  end
  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_engine.sv
// tb_hilo_muldiv_engine: directed checks of hilo_muldiv_engine timing, arithmetic and collisions.
module tb_hilo_muldiv_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] src_a = '0, src_b = '0;
  logic        hilo_sel = 1'b0, start = 1'b0, hilo_we = 1'b0;
  logic [2:0]  op = '0;
  logic        busy;
  logic [31:0] hi, lo;
  int          tests = 0, fails = 0;

  hilo_muldiv_engine dut (
    .clk(clk), .reset(reset), .src_a(src_a), .src_b(src_b), .hilo_sel(hilo_sel),
    .op(op), .start(start), .hilo_we(hilo_we), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic move_to(input logic sel, input logic [31:0] v);
    hilo_we = 1'b1; hilo_sel = sel; src_a = v;
    tick();
    hilo_we = 1'b0;
  endtask

  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; src_a = a; src_b = b; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 50) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi got %h want 0", hi); end
    tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo got %h want 0", lo); end
    tick(); reset = 1'b0; tick();
    move_to(1'b1, 32'h55);
    move_to(1'b0, 32'h66);
    launch(3'b000, 32'd3, 32'd4);
    tick();
    reset = 1'b1;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrun_busy got %b want 0", busy); end
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL midrun_hi got %h want 0", hi); end
    tests++; if (lo !== 32'h0) begin fails++; $display("FAIL midrun_lo got %h want 0", lo); end
    tick(); reset = 1'b0;
    repeat (8) tick();
    tests++; if (hi !== 32'h0 || lo !== 32'h0 || busy !== 1'b0) begin
      fails++; $display("FAIL midrun_later got hi=%h lo=%h busy=%b want 0/0/0", hi, lo, busy);
    end
  endtask

  task automatic test_multu();
    int n;
    launch(3'b000, 32'hFFFFFFFF, 32'h2);
    wait_idle(n);
    tests++; if (n != 5) begin fails++; $display("FAIL multu_busy got %0d want 5", n); end
    tests++; if (hi !== 32'h1) begin fails++; $display("FAIL multu_hi got %h want 00000001", hi); end
    tests++; if (lo !== 32'hFFFFFFFE) begin fails++; $display("FAIL multu_lo got %h want fffffffe", lo); end
  endtask

  task automatic test_mult();
    int n;
    launch(3'b001, 32'hFFFFFFFD, 32'd7);
    wait_idle(n);
    tests++; if (n != 5) begin fails++; $display("FAIL mult_busy got %0d want 5", n); end
    tests++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    tests++; if (lo !== 32'hFFFFFFEB) begin fails++; $display("FAIL mult_lo got %h want ffffffeb", lo); end
  endtask

  task automatic test_div();
    int n;
    launch(3'b011, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    tests++; if (n != 10) begin fails++; $display("FAIL div_busy got %0d want 10", n); end
    tests++; if (lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_lo got %h want fffffffd", lo); end
    tests++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_hi got %h want ffffffff", hi); end
    launch(3'b011, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    tests++; if (lo !== 32'h80000000) begin fails++; $display("FAIL divovf_lo got %h want 80000000", lo); end
    tests++; if (hi !== 32'h0) begin fails++; $display("FAIL divovf_hi got %h want 0", hi); end
    launch(3'b010, 32'd100, 32'd7);
    wait_idle(n);
    tests++; if (lo !== 32'd14 || hi !== 32'd2) begin
      fails++; $display("FAIL divu got lo=%h hi=%h want 0000000e/00000002", lo, hi);
    end
    launch(3'b011, 32'd7, 32'hFFFFFFFE);
    wait_idle(n);
    tests++; if (lo !== 32'hFFFFFFFD || hi !== 32'd1) begin
      fails++; $display("FAIL div_negdivisor got lo=%h hi=%h want fffffffd/00000001", lo, hi);
    end
  endtask

  task automatic test_divzero();
    int n;
    move_to(1'b1, 32'h11);
    move_to(1'b0, 32'h22);
    launch(3'b010, 32'd5, 32'd0);
    n = 0;
    while (busy && n < 50) begin
      n++;
      if (n == 3) begin
        start = 1'b1; op = 3'b000; hilo_we = 1'b1; hilo_sel = 1'b1; src_a = 32'h99; src_b = 32'd1;
      end else begin
        start = 1'b0; hilo_we = 1'b0;
      end
      tick();
    end
    start = 1'b0; hilo_we = 1'b0;
    tests++; if (n != 10) begin fails++; $display("FAIL divzero_busy got %0d want 10", n); end
    tests++; if (hi !== 32'h11) begin fails++; $display("FAIL divzero_hi got %h want 00000011", hi); end
    tests++; if (lo !== 32'h22) begin fails++; $display("FAIL divzero_lo got %h want 00000022", lo); end
    repeat (3) tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL divzero_nosecond got busy=%b want 0", busy); end
  endtask

  task automatic test_reserved();
    launch(3'b100, 32'd9, 32'd9);
    tests++; if (busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) begin
      fails++; $display("FAIL reserved got busy=%b hi=%h lo=%h want 0/11/22", busy, hi, lo);
    end
  endtask

  task automatic test_collision();
    int n;
    hilo_we = 1'b1; hilo_sel = 1'b0;
    launch(3'b000, 32'd2, 32'd3);
    hilo_we = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL collide_busy got %b want 1", busy); end
    wait_idle(n);
    tests++; if (lo !== 32'd6) begin fails++; $display("FAIL collide_lo got %h want 00000006", lo); end
    tests++; if (hi !== 32'd0) begin fails++; $display("FAIL collide_hi got %h want 0", hi); end
    move_to(1'b0, 32'hABCD);
    tests++; if (lo !== 32'hABCD) begin fails++; $display("FAIL mtlo_lo got %h want 0000abcd", lo); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mtlo_busy got %b want 0", busy); end
    tests++; if (hi !== 32'd0) begin fails++; $display("FAIL mtlo_hi got %h want 0", hi); end
  endtask

  task automatic test_back_to_back();
    int n;
    launch(3'b000, 32'h10000, 32'h10000);
    wait_idle(n);
    launch(3'b001, 32'h7FFFFFFF, 32'h7FFFFFFF);
    src_a = 32'h1234; src_b = 32'h5678;
    wait_idle(n);
    tests++; if (n != 5) begin fails++; $display("FAIL b2b_busy got %0d want 5", n); end
    tests++; if (hi !== 32'h3FFFFFFF || lo !== 32'h00000001) begin
      fails++; $display("FAIL b2b got hi=%h lo=%h want 3fffffff/00000001", hi, lo);
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult();
    test_div();
    test_divzero();
    test_reserved();
    test_collision();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
